// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: RAM geometry, bus width and the
// program-load arbiter state encoding.
package cpu_pkg;

  localparam int RAM_DEPTH  = 16;
  localparam int RAM_ADDR_W = 4;
  localparam int BUS_W      = 8;

  // RUN passes the control block through; the others form the load sequence
  // WAIT_BYTE -> ADDR -> DATA -> WRITE (one cycle each after acceptance).
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_WRITE     = 3'd4
  } load_state_t;

endpackage

// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter
// Arbitrates the MAR/RAM load path between the CPU control block and an
// external program-load port. In RUN the control-block strobes pass straight
// through. In the load states the CPU is held, the arbiter drives the bus and
// runs an address / data / write cycle for every accepted byte.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   load_req                     level request for program-load mode
//   prog_valid/prog_data/
//   prog_last/prog_ready         byte handshake (see below)
//   cpu_n_lma/lmd/lr/ce          control-block strobes (active-low)
//   n_lma/n_lmd/n_lr/n_ce        strobes to MAR/RAM (active-low)
//   bus_oe, bus_out              arbiter bus drive (bus_out is 0 when idle)
//   cpu_hold                     freezes PC / control-block sequencing
//   cpu_restart                  one-cycle pulse in the first RUN cycle after a load
//   load_addr                    current write address
//   dbg_state                    current FSM state
//
// Handshake: a byte transfers on a rising clock edge where prog_valid and
// prog_ready are both 1. prog_ready is 1 only in WAIT_BYTE, so prog_valid is
// ignored (no byte consumed) in every other state. prog_valid may not depend
// on prog_ready being low; the producer simply holds the byte until accepted.
module ram_load_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = BUS_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  input  logic              cpu_n_lma,
  input  logic              cpu_n_lmd,
  input  logic              cpu_n_lr,
  input  logic              cpu_n_ce,
  output logic              n_lma,
  output logic              n_lmd,
  output logic              n_lr,
  output logic              n_ce,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_out,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic [ADDR_W-1:0] load_addr,
  output load_state_t       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              restart_q, restart_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      restart_q <= restart_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    restart_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (load_req) begin
          state_d = ST_WAIT_BYTE;
          addr_d  = '0;
        end
      end
      ST_WAIT_BYTE: begin
        if (prog_valid) begin
          data_d  = prog_data;
          last_d  = prog_last;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR:  state_d = ST_DATA;
      ST_DATA:  state_d = ST_WRITE;
      ST_WRITE: begin
        // The last RAM address ends the load even without prog_last; no wrap.
        if (last_q || (addr_q == LAST_ADDR)) begin
          state_d   = ST_RUN;
          restart_d = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_WAIT_BYTE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode: everything comes from registered state except the RUN
  // pass-through of the control-block strobes.
  always_comb begin
    n_lma      = 1'b1;
    n_lmd      = 1'b1;
    n_lr       = 1'b1;
    n_ce       = 1'b1;
    bus_oe     = 1'b0;
    bus_out    = '0;
    cpu_hold   = 1'b1;
    prog_ready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        n_lma    = cpu_n_lma;
        n_lmd    = cpu_n_lmd;
        n_lr     = cpu_n_lr;
        n_ce     = cpu_n_ce;
        cpu_hold = 1'b0;
      end
      ST_WAIT_BYTE: prog_ready = 1'b1;
      ST_ADDR: begin
        bus_oe  = 1'b1;
        bus_out = DATA_W'(addr_q);
        n_lma   = 1'b0;
      end
      ST_DATA: begin
        bus_oe  = 1'b1;
        bus_out = data_q;
        n_lmd   = 1'b0;
      end
      ST_WRITE: n_lr = 1'b0;
      default: ;
    endcase
  end

  assign cpu_restart = restart_q;
  assign load_addr   = addr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_load_arbiter.sv
module tb_ram_load_arbiter;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       load_req, prog_valid, prog_last, prog_ready;
  logic [7:0] prog_data;
  logic       cpu_n_lma, cpu_n_lmd, cpu_n_lr, cpu_n_ce;
  logic       n_lma, n_lmd, n_lr, n_ce;
  logic       bus_oe, cpu_hold, cpu_restart;
  logic [7:0] bus_out;
  logic [3:0] load_addr;
  load_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  ram_load_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .load_req(load_req), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready),
    .cpu_n_lma(cpu_n_lma), .cpu_n_lmd(cpu_n_lmd), .cpu_n_lr(cpu_n_lr), .cpu_n_ce(cpu_n_ce),
    .n_lma(n_lma), .n_lmd(n_lmd), .n_lr(n_lr), .n_ce(n_ce),
    .bus_oe(bus_oe), .bus_out(bus_out), .cpu_hold(cpu_hold),
    .cpu_restart(cpu_restart), .load_addr(load_addr), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_req   = 1'b0;
    prog_valid = 1'b0;
    prog_data  = 8'h00;
    prog_last  = 1'b0;
    cpu_n_lma  = 1'b1;
    cpu_n_lmd  = 1'b1;
    cpu_n_lr   = 1'b1;
    cpu_n_ce   = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    load_req = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_RUN || prog_ready !== 1'b0 || bus_oe !== 1'b0 || bus_out !== 8'h00 ||
        cpu_hold !== 1'b0 || cpu_restart !== 1'b0 || load_addr !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d rdy=%b oe=%b bus=%h hold=%b rst_p=%b addr=%h, expected RUN 0 0 00 0 0 0",
               dbg_state, prog_ready, bus_oe, bus_out, cpu_hold, cpu_restart, load_addr);
    end
    load_req = 1'b0;
    cpu_n_lr = 1'b0;
    #1;
    n_checks++;
    if (n_lr !== 1'b0) begin n_fail++; $display("FAIL reset_passthru_lr_low: n_lr=%b expected 0", n_lr); end
    cpu_n_lr  = 1'b1;
    cpu_n_lma = 1'b0;
    cpu_n_ce  = 1'b0;
    #1;
    n_checks++;
    if ({n_lma, n_lmd, n_lr, n_ce} !== 4'b0110) begin
      n_fail++; $display("FAIL reset_passthru: strobes=%b expected 0110", {n_lma, n_lmd, n_lr, n_ce});
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== ST_RUN || cpu_hold !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_run: state=%0d hold=%b expected RUN 0", dbg_state, cpu_hold);
    end
  endtask

  task automatic test_single_byte();
    load_req = 1'b1;
    n_checks++;
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL hold_before_req_edge: %b expected 0", cpu_hold); end
    tick();
    load_req = 1'b0;
    n_checks++;
    if (dbg_state !== ST_WAIT_BYTE || cpu_hold !== 1'b1 || prog_ready !== 1'b1) begin
      n_fail++; $display("FAIL enter_wait: state=%0d hold=%b rdy=%b expected WAIT 1 1", dbg_state, cpu_hold, prog_ready);
    end
    prog_valid = 1'b1; prog_data = 8'h1E; prog_last = 1'b1;
    tick();
    prog_valid = 1'b0; prog_data = 8'h00; prog_last = 1'b0;
    n_checks++;
    if (bus_oe !== 1'b1 || bus_out !== 8'h00 || {n_lma, n_lmd, n_lr, n_ce} !== 4'b0111 || prog_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_addr: oe=%b bus=%h strobes=%b rdy=%b expected 1 00 0111 0",
                         bus_oe, bus_out, {n_lma, n_lmd, n_lr, n_ce}, prog_ready);
    end
    tick();
    n_checks++;
    if (bus_oe !== 1'b1 || bus_out !== 8'h1E || {n_lma, n_lmd, n_lr, n_ce} !== 4'b1011) begin
      n_fail++; $display("FAIL single_data: oe=%b bus=%h strobes=%b expected 1 1e 1011",
                         bus_oe, bus_out, {n_lma, n_lmd, n_lr, n_ce});
    end
    tick();
    n_checks++;
    if (bus_oe !== 1'b0 || bus_out !== 8'h00 || {n_lma, n_lmd, n_lr, n_ce} !== 4'b1101 || cpu_restart !== 1'b0) begin
      n_fail++; $display("FAIL single_write: oe=%b bus=%h strobes=%b restart=%b expected 0 00 1101 0",
                         bus_oe, bus_out, {n_lma, n_lmd, n_lr, n_ce}, cpu_restart);
    end
    tick();
    n_checks++;
    if (cpu_restart !== 1'b1 || cpu_hold !== 1'b0 || dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL single_restart: restart=%b hold=%b state=%0d expected 1 0 RUN", cpu_restart, cpu_hold, dbg_state);
    end
    tick();
    n_checks++;
    if (cpu_restart !== 1'b0 || dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL restart_one_cycle: restart=%b state=%0d expected 0 RUN", cpu_restart, dbg_state);
    end
  endtask

  // 16 back-to-back bytes, prog_last never set, CPU strobes all asserted low
  // so any leak through the arbiter shows up.
  task automatic test_full_load();
    int cycles;
    logic [7:0] d, exp_d;
    cpu_n_lma = 1'b0; cpu_n_lmd = 1'b0; cpu_n_lr = 1'b0; cpu_n_ce = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    cycles = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 17 + 3);
      exp_q.push_back(d);
      n_checks++;
      if (dbg_state !== ST_WAIT_BYTE || load_addr !== 4'(i) || n_ce !== 1'b1) begin
        n_fail++; $display("FAIL full_wait[%0d]: state=%0d addr=%h n_ce=%b expected WAIT %h 1", i, dbg_state, load_addr, n_ce, i);
      end
      prog_valid = 1'b1; prog_data = d; prog_last = 1'b0;
      tick(); cycles++;
      prog_valid = 1'b0;
      n_checks++;
      if (bus_out !== 8'(i) || n_lma !== 1'b0 || n_ce !== 1'b1 || n_lr !== 1'b1) begin
        n_fail++; $display("FAIL full_addr[%0d]: bus=%h n_lma=%b n_ce=%b n_lr=%b expected %h 0 1 1", i, bus_out, n_lma, n_ce, n_lr, i);
      end
      tick(); cycles++;
      exp_d = exp_q.pop_front();
      n_checks++;
      if (bus_out !== exp_d || n_lmd !== 1'b0 || n_ce !== 1'b1) begin
        n_fail++; $display("FAIL full_data[%0d]: bus=%h n_lmd=%b n_ce=%b expected %h 0 1", i, bus_out, n_lmd, n_ce, exp_d);
      end
      tick(); cycles++;
      n_checks++;
      if (n_lr !== 1'b0 || n_ce !== 1'b1 || n_lma !== 1'b1 || cpu_hold !== 1'b1) begin
        n_fail++; $display("FAIL full_write[%0d]: n_lr=%b n_ce=%b n_lma=%b hold=%b expected 0 1 1 1", i, n_lr, n_ce, n_lma, cpu_hold);
      end
      tick(); cycles++;
    end
    n_checks++;
    if (cycles !== 64 || dbg_state !== ST_RUN || cpu_restart !== 1'b1 || load_addr !== 4'hF) begin
      n_fail++; $display("FAIL full_end: cycles=%0d state=%0d restart=%b addr=%h expected 64 RUN 1 f",
                         cycles, dbg_state, cpu_restart, load_addr);
    end
    n_checks++;
    if (n_ce !== 1'b0) begin n_fail++; $display("FAIL full_passthru_back: n_ce=%b expected 0", n_ce); end
    idle_inputs();
    tick();
  endtask

  task automatic test_handshake_gaps();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (prog_ready !== 1'b1 || {n_lma, n_lmd, n_lr, n_ce} !== 4'b1111 || load_addr !== 4'h0 || bus_oe !== 1'b0) begin
        n_fail++; $display("FAIL gap[%0d]: rdy=%b strobes=%b addr=%h oe=%b expected 1 1111 0 0",
                           i, prog_ready, {n_lma, n_lmd, n_lr, n_ce}, load_addr, bus_oe);
      end
    end
    prog_valid = 1'b1; prog_data = 8'h5A; prog_last = 1'b0;
    tick();                       // ADDR
    prog_valid = 1'b0;
    tick();                       // DATA: offer a stray byte
    prog_valid = 1'b1; prog_data = 8'hC3; prog_last = 1'b1;
    n_checks++;
    if (prog_ready !== 1'b0 || bus_out !== 8'h5A) begin
      n_fail++; $display("FAIL gap_data: rdy=%b bus=%h expected 0 5a", prog_ready, bus_out);
    end
    tick();                       // WRITE
    prog_valid = 1'b0;
    tick();                       // back to WAIT_BYTE, stray byte not taken
    n_checks++;
    if (dbg_state !== ST_WAIT_BYTE || load_addr !== 4'h1 || prog_ready !== 1'b1) begin
      n_fail++; $display("FAIL gap_ignored: state=%0d addr=%h rdy=%b expected WAIT 1 1", dbg_state, load_addr, prog_ready);
    end
    prog_valid = 1'b1; prog_data = 8'h77; prog_last = 1'b1;
    tick(); prog_valid = 1'b0; prog_last = 1'b0;
    tick();
    n_checks++;
    if (bus_out !== 8'h77) begin n_fail++; $display("FAIL gap_second_data: bus=%h expected 77", bus_out); end
    tick(); tick();
    n_checks++;
    if (cpu_restart !== 1'b1) begin n_fail++; $display("FAIL gap_restart: restart=%b expected 1", cpu_restart); end
    tick();
  endtask

  // load_req stays high through three bytes, then drops; then a second load
  // with load_req held checks immediate re-entry at address 0.
  task automatic test_load_req_drop();
    load_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) load_req = 1'b0;
      prog_valid = 1'b1; prog_data = 8'(8'h40 + i); prog_last = (i == 3);
      tick(); prog_valid = 1'b0; prog_last = 1'b0;
      tick(); tick(); tick();
    end
    n_checks++;
    if (dbg_state !== ST_RUN || cpu_restart !== 1'b1 || load_addr !== 4'h3) begin
      n_fail++; $display("FAIL drop_continues: state=%0d restart=%b addr=%h expected RUN 1 3", dbg_state, cpu_restart, load_addr);
    end
    tick();
    load_req = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1; prog_data = 8'h11; prog_last = (i == 1);
      tick(); prog_valid = 1'b0; prog_last = 1'b0;
      tick(); tick(); tick();
    end
    n_checks++;
    if (dbg_state !== ST_RUN || cpu_restart !== 1'b1 || cpu_hold !== 1'b0 || load_addr !== 4'h1) begin
      n_fail++; $display("FAIL reentry_restart: state=%0d restart=%b hold=%b addr=%h expected RUN 1 0 1",
                         dbg_state, cpu_restart, cpu_hold, load_addr);
    end
    tick();
    n_checks++;
    if (dbg_state !== ST_WAIT_BYTE || load_addr !== 4'h0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL reentry_wait: state=%0d addr=%h hold=%b expected WAIT 0 1", dbg_state, load_addr, cpu_hold);
    end
    load_req = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    // Still in WAIT_BYTE from the previous scenario.
    prog_valid = 1'b1; prog_data = 8'h99; prog_last = 1'b0;
    tick(); prog_valid = 1'b0;
    tick();                       // DATA
    n_checks++;
    if (dbg_state !== ST_DATA || bus_oe !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_data: state=%0d oe=%b expected DATA 1", dbg_state, bus_oe);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== ST_RUN || cpu_hold !== 1'b0 || bus_oe !== 1'b0 || bus_out !== 8'h00 || load_addr !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_load: state=%0d hold=%b oe=%b bus=%h addr=%h expected RUN 0 0 00 0",
                         dbg_state, cpu_hold, bus_oe, bus_out, load_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== ST_RUN || cpu_restart !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_idle: state=%0d restart=%b expected RUN 0", dbg_state, cpu_restart);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    apply_reset();
    test_reset();
    test_single_byte();
    test_full_load();
    test_handshake_gaps();
    test_load_req_drop();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
